// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcodes, FSM states and datapath select encodings shared by the
// multicycle controller, alu_dec and the datapath.
package multicycle_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_e;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping count of retired instructions, async active-low reset.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath.
// Define MULTICYCLE_CTRL_BNE_EN to accept bne (000101) as a branch.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int RET_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OP_W-1:0]    op_i6,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               iord_o,
  output logic               enable_wmem_o,
  output logic               ir_write_o,
  output logic               alu_wreg_o,
  output logic               reg_dst_rtrd_o,
  output logic               enable_wreg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o2,
  output logic [1:0]         alu_op_o2,
  output logic [1:0]         pc_src_o2,
  output logic               pc_write_en_o,
  output logic               illegal_op_o,
  output logic [RET_W-1:0]   instr_retired_o,
  output logic [STATE_W-1:0] state_o
);
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif
  state_e state, next;
  logic mem_req, wmem, ir, wreg, pc_write, branch, illegal, retire, taken;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= FETCH;
    else state <= next;
  // bne inverts the sense of the zero flag; the IR is stable through BRANCH
  assign taken = (BNE_EN && op_i6 == OP_BNE) ? ~zero_i : zero_i;
  always_comb begin
    next = FETCH;
    mem_req = 1'b0;
    iord_o = 1'b0;
    wmem = 1'b0;
    ir = 1'b0;
    alu_wreg_o = 1'b0;
    reg_dst_rtrd_o = 1'b0;
    wreg = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o2 = SRCB_REG;
    alu_op_o2 = ALU_ADD;
    pc_src_o2 = PC_ALU;
    pc_write = 1'b0;
    branch = 1'b0;
    illegal = 1'b0;
    retire = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b_o2 = SRCB_FOUR;
        ir = mem_ready_i;
        pc_write = mem_ready_i;
        next = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o2 = SRCB_IMMSH;
        case (op_i6)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXECUTE;
          OP_BEQ:       next = BRANCH;
          OP_BNE: begin
            next = BNE_EN ? BRANCH : FETCH;
            illegal = !BNE_EN;
          end
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o2 = SRCB_IMM;
        next = (op_i6 == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord_o = 1'b1;
        next = mem_ready_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        wreg = 1'b1;
        alu_wreg_o = 1'b1;
        retire = 1'b1;
      end
      MEMWR: begin
        mem_req = 1'b1;
        iord_o = 1'b1;
        wmem = mem_ready_i;
        retire = mem_ready_i;
        next = mem_ready_i ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o2 = ALU_FUNCT;
        next = ALUWB;
      end
      ALUWB: begin
        wreg = 1'b1;
        reg_dst_rtrd_o = 1'b1;
        retire = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o2 = ALU_SUB;
        pc_src_o2 = PC_ALUOUT;
        branch = 1'b1;
        retire = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o2 = SRCB_IMM;
        next = ADDIWB;
      end
      ADDIWB: begin
        wreg = 1'b1;
        retire = 1'b1;
      end
      JUMP: begin
        pc_src_o2 = PC_JUMP;
        pc_write = 1'b1;
        retire = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  assign mem_req_o = mem_req & rst_ni;
  assign enable_wmem_o = wmem & rst_ni;
  assign ir_write_o = ir & rst_ni;
  assign enable_wreg_o = wreg & rst_ni;
  assign pc_write_en_o = (pc_write | (branch & taken)) & rst_ni;
  assign illegal_op_o = illegal & rst_ni;
  assign state_o = state;
  retire_counter #(.W(RET_W)) u_retire (
    .clk(clk_i),
    .rst_n(rst_ni),
    .inc(retire & rst_ni),
    .count(instr_retired_o)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked every cycle
// against a per-instruction behavioural model of the control outputs.
module tb_multicycle_controller;
  import multicycle_pkg::*;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op = '0;
  logic zero = 1'b0, ready = 1'b0;
  logic mem_req, iord, wmem, ir_write, alu_wreg, reg_dst, wreg, src_a, pc_we, illegal;
  logic [1:0] src_b, alu_op, pc_src;
  logic [3:0] retired, state;
  int n_cmp = 0, n_fail = 0;
  logic chk = 1'b0;
  logic [3:0] ret_m = '0;
  state_e exp_state = FETCH;
  logic [15:0] exp_vec = '0;
  logic [15:0] dut_vec;
  always #5 clk = ~clk;
  multicycle_controller #(.OP_W(6), .RET_W(4), .STATE_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i6(op), .zero_i(zero), .mem_ready_i(ready),
    .mem_req_o(mem_req), .iord_o(iord), .enable_wmem_o(wmem), .ir_write_o(ir_write),
    .alu_wreg_o(alu_wreg), .reg_dst_rtrd_o(reg_dst), .enable_wreg_o(wreg),
    .alu_src_a_o(src_a), .alu_src_b_o2(src_b), .alu_op_o2(alu_op), .pc_src_o2(pc_src),
    .pc_write_en_o(pc_we), .illegal_op_o(illegal), .instr_retired_o(retired), .state_o(state)
  );
  assign dut_vec = {mem_req, iord, wmem, ir_write, alu_wreg, reg_dst, wreg, src_a,
                    src_b, alu_op, pc_src, pc_we, illegal};
  function automatic bit legal(logic [5:0] o);
    return o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (BNE && o == OP_BNE);
  endfunction
  // Expected control word for one cycle of the named instruction phase
  function automatic logic [15:0] model(state_e s, logic [5:0] o, logic z, logic rdy);
    logic mr = 0, io = 0, wm = 0, irw = 0, aw = 0, rd = 0, wr = 0, sa = 0, pw = 0, il = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    if (s == FETCH) begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
    if (s == DECODE) begin sb = 2'b11; il = !legal(o); end
    if (s == MEMADR || s == ADDIEX) begin sa = 1; sb = 2'b10; end
    if (s == MEMRD || s == MEMWR) begin mr = 1; io = 1; wm = (s == MEMWR) && rdy; end
    if (s == MEMWB || s == ALUWB || s == ADDIWB) begin wr = 1; aw = (s == MEMWB); rd = (s == ALUWB); end
    if (s == EXECUTE) begin sa = 1; ao = 2'b10; end
    if (s == BRANCH) begin sa = 1; ao = 2'b01; ps = 2'b01; pw = (o == OP_BNE) ? !z : z; end
    if (s == JUMP) begin ps = 2'b10; pw = 1; end
    return {mr, io, wm, irw, aw, rd, wr, sa, sb, ao, ps, pw, il};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk) begin
    check($sformatf("state_%s", exp_state.name()), {28'd0, state}, {28'd0, exp_state});
    check($sformatf("ctrl_%s", exp_state.name()), {16'd0, dut_vec}, {16'd0, exp_vec});
    check("retired", {28'd0, retired}, {28'd0, ret_m});
  end
  task automatic step(state_e s, logic rdy, logic ret);
    ready = rdy;
    exp_state = s;
    exp_vec = model(s, op, zero, rdy);
    chk = 1'b1;
    @(posedge clk);
    #1;
    if (ret) ret_m = ret_m + 1'b1;
  endtask
  task automatic exec(logic [5:0] o, logic z, int fw, int mw);
    op = o;
    zero = z;
    repeat (fw) step(FETCH, 1'b0, 1'b0);
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, 1'b1, 1'b0);
    if (o == OP_LW) begin
      step(MEMADR, 1'b1, 1'b0);
      repeat (mw) step(MEMRD, 1'b0, 1'b0);
      step(MEMRD, 1'b1, 1'b0);
      step(MEMWB, 1'b1, 1'b1);
    end else if (o == OP_SW) begin
      step(MEMADR, 1'b1, 1'b0);
      repeat (mw) step(MEMWR, 1'b0, 1'b0);
      step(MEMWR, 1'b1, 1'b1);
    end else if (o == OP_RTYPE) begin
      step(EXECUTE, 1'b0, 1'b0);
      step(ALUWB, 1'b1, 1'b1);
    end else if (o == OP_ADDI) begin
      step(ADDIEX, 1'b1, 1'b0);
      step(ADDIWB, 1'b0, 1'b1);
    end else if (o == OP_BEQ || (BNE && o == OP_BNE)) begin
      step(BRANCH, 1'b1, 1'b1);
    end else if (o == OP_J) begin
      step(JUMP, 1'b1, 1'b1);
    end
  endtask
  task automatic check_reset(string tag);
    check({tag, "_state"}, {28'd0, state}, 32'd0);
    check({tag, "_retired"}, {28'd0, retired}, 32'd0);
    check({tag, "_enables"}, {26'd0, mem_req, wmem, ir_write, wreg, pc_we, illegal}, 32'd0);
  endtask
  initial begin
    #2 check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    exec(OP_LW, 1'b0, 0, 0);
    check("lw_retired", {28'd0, retired}, 32'd1);
    check("lw_back_to_fetch", {28'd0, state}, 32'd0);
    exec(OP_RTYPE, 1'b0, 3, 0);
    check("rtype_retired", {28'd0, retired}, 32'd2);
    exec(OP_BEQ, 1'b1, 0, 0);
    exec(OP_BEQ, 1'b0, 0, 0);
    check("beq_retired", {28'd0, retired}, 32'd4);
    exec(OP_BNE, 1'b0, 0, 0);
    check("bne_retired", {28'd0, retired}, BNE ? 32'd5 : 32'd4);
    exec(OP_SW, 1'b0, 1, 2);
    exec(OP_ADDI, 1'b0, 0, 0);
    exec(OP_J, 1'b0, 0, 0);
    exec(6'b111111, 1'b0, 0, 0);
    check("mix_retired", {28'd0, retired}, BNE ? 32'd8 : 32'd7);
    op = OP_LW;
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, 1'b1, 1'b0);
    step(MEMADR, 1'b1, 1'b0);
    step(MEMRD, 1'b0, 1'b0);
    chk = 1'b0;
    rst_n = 1'b0;
    ret_m = '0;
    #1 check_reset("midrd");
    @(posedge clk);
    #1 check_reset("midrd_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exec(OP_RTYPE, 1'b0, 0, 0);
      if (i == 14) check("wrap_15", {28'd0, retired}, 32'd15);
    end
    check("wrap_0", {28'd0, retired}, 32'd0);
    chk = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
